// File: rtl/qracc_pkg.sv
// Shared types and constants for the QRAcc pass sequencer.
package qracc_pkg;

  localparam int QRACC_SEQ_CNT_W = 16;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_LOAD,
    SEQ_DRAIN,
    SEQ_MAC,
    SEQ_WAIT,
    SEQ_WRITE,
    SEQ_DONE
  } seq_state_t;

endpackage

// File: rtl/qracc_seq_addr_gen.sv
// Address accumulator: loads a base, then adds a stride on every step.
module qracc_seq_addr_gen #(
  parameter int addrWidth = 32
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 load,
  input  logic                 step,
  input  logic [addrWidth-1:0] base,
  input  logic [addrWidth-1:0] stride,
  output logic [addrWidth-1:0] addr
);

  logic [addrWidth-1:0] addr_reg;

  // Wraps modulo 2^addrWidth by construction.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_reg <= '0;
    end else if (load) begin
      addr_reg <= base;
    end else if (step) begin
      addr_reg <= addr_reg + stride;
    end
  end

  assign addr = addr_reg;

endmodule

// File: rtl/qracc_pass_sequencer.sv
// Sequences one QRAcc layer pass: buffer reads -> feature loader -> seq_acc MAC -> writeback.
// Define QRACC_SEQ_PERF_CNT_EN to add the perf_cycles_o / perf_stall_o counters.
module qracc_pass_sequencer
  import qracc_pkg::*;
#(
  parameter int addrWidth   = 32,
  parameter int cntWidth    = QRACC_SEQ_CNT_W,
  parameter int flAddrWidth = 32
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   start_i,
  input  logic                   clear_i,
  input  logic [cntWidth-1:0]    num_pixels_i,
  input  logic [cntWidth-1:0]    num_loads_i,
  input  logic [addrWidth-1:0]   rd_base_i,
  input  logic [addrWidth-1:0]   rd_stride_i,
  input  logic [addrWidth-1:0]   wr_base_i,
  input  logic [addrWidth-1:0]   wr_stride_i,
  output logic                   buf_rd_en_o,
  output logic [addrWidth-1:0]   buf_rd_addr_o,
  output logic                   fl_wr_en_o,
  output logic [flAddrWidth-1:0] fl_addr_o,
  output logic                   mac_valid_o,
  input  logic                   mac_ready_i,
  input  logic                   mac_done_i,
  output logic                   wb_en_o,
  output logic [addrWidth-1:0]   wb_addr_o,
  input  logic                   wb_ready_i,
  output logic                   busy_o,
  output logic                   done_o,
`ifdef QRACC_SEQ_PERF_CNT_EN
  output logic [31:0]            perf_cycles_o,
  output logic [31:0]            perf_stall_o,
`endif
  output logic                   err_o
);

  seq_state_t state_reg, state_next;
  logic [cntWidth-1:0]    num_pixels_reg, num_loads_reg, load_idx_reg, pix_idx_reg;
  logic [addrWidth-1:0]   rd_stride_reg, wr_stride_reg;
  logic                   fl_wr_en_reg, busy_reg, done_reg, err_reg;
  logic [flAddrWidth-1:0] fl_addr_reg;
  logic                   start_acc, last_load, last_pixel, wb_fire;

  assign start_acc  = (state_reg == SEQ_IDLE) && start_i && !clear_i;
  assign last_load  = (load_idx_reg == num_loads_reg - cntWidth'(1));
  assign last_pixel = (pix_idx_reg == num_pixels_reg - cntWidth'(1));
  assign wb_fire    = (state_reg == SEQ_WRITE) && wb_ready_i;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SEQ_IDLE:  if (start_i) state_next = (num_pixels_i == '0) ? SEQ_DONE : SEQ_LOAD;
      SEQ_LOAD:  if (last_load) state_next = SEQ_DRAIN;
      SEQ_DRAIN: state_next = SEQ_MAC;
      SEQ_MAC:   if (mac_ready_i) state_next = SEQ_WAIT;
      SEQ_WAIT:  if (mac_done_i) state_next = SEQ_WRITE;
      SEQ_WRITE: if (wb_ready_i) state_next = last_pixel ? SEQ_DONE : SEQ_LOAD;
      SEQ_DONE:  state_next = SEQ_IDLE;
      default:   state_next = SEQ_IDLE;
    endcase
    if (clear_i) state_next = SEQ_IDLE;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg      <= SEQ_IDLE;
      num_pixels_reg <= '0;
      num_loads_reg  <= '0;
      load_idx_reg   <= '0;
      pix_idx_reg    <= '0;
      rd_stride_reg  <= '0;
      wr_stride_reg  <= '0;
      fl_wr_en_reg   <= 1'b0;
      fl_addr_reg    <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start_acc) begin
        num_pixels_reg <= num_pixels_i;
        num_loads_reg  <= (num_loads_i == '0) ? cntWidth'(1) : num_loads_i;
        rd_stride_reg  <= rd_stride_i;
        wr_stride_reg  <= wr_stride_i;
        load_idx_reg   <= '0;
        pix_idx_reg    <= '0;
      end else begin
        if (state_reg == SEQ_LOAD) load_idx_reg <= last_load ? '0 : load_idx_reg + cntWidth'(1);
        if (wb_fire && !last_pixel) pix_idx_reg <= pix_idx_reg + cntWidth'(1);
      end
      // Buffer data arrives one cycle after the read, so the loader write trails it.
      fl_wr_en_reg <= (state_reg == SEQ_LOAD) && !clear_i;
      fl_addr_reg  <= flAddrWidth'(load_idx_reg);
      busy_reg     <= (state_next != SEQ_IDLE);
      done_reg     <= (state_reg == SEQ_DONE) && !clear_i;
      if (clear_i) err_reg <= 1'b0;
      else if (mac_done_i && state_reg != SEQ_WAIT) err_reg <= 1'b1;
      else if (start_acc) err_reg <= 1'b0;
    end
  end

  // Instance 0 walks read addresses (contiguous across pixels), instance 1 walks writebacks.
  logic [1:0]           ag_load, ag_step;
  logic [addrWidth-1:0] ag_base [2];
  logic [addrWidth-1:0] ag_stride [2];
  logic [addrWidth-1:0] ag_addr [2];

  assign ag_load      = {start_acc, start_acc};
  assign ag_step      = {wb_fire, (state_reg == SEQ_LOAD)};
  assign ag_base[0]   = rd_base_i;
  assign ag_base[1]   = wr_base_i;
  assign ag_stride[0] = rd_stride_reg;
  assign ag_stride[1] = wr_stride_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_addr
      qracc_seq_addr_gen #(.addrWidth(addrWidth)) u_addr_gen (
        .clk    (clk),
        .nrst   (nrst),
        .load   (ag_load[gi]),
        .step   (ag_step[gi]),
        .base   (ag_base[gi]),
        .stride (ag_stride[gi]),
        .addr   (ag_addr[gi])
      );
    end
  endgenerate

  assign buf_rd_en_o   = (state_reg == SEQ_LOAD);
  assign buf_rd_addr_o = ag_addr[0];
  assign fl_wr_en_o    = fl_wr_en_reg;
  assign fl_addr_o     = fl_addr_reg;
  assign mac_valid_o   = (state_reg == SEQ_MAC);
  assign wb_en_o       = (state_reg == SEQ_WRITE);
  assign wb_addr_o     = ag_addr[1];
  assign busy_o        = busy_reg;
  assign done_o        = done_reg;
  assign err_o         = err_reg;

`ifdef QRACC_SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles_reg, perf_stall_reg;
  logic        stall_cond;

  assign stall_cond = ((state_reg == SEQ_MAC) && !mac_ready_i) || (state_reg == SEQ_WAIT) ||
                      ((state_reg == SEQ_WRITE) && !wb_ready_i);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      perf_cycles_reg <= '0;
      perf_stall_reg  <= '0;
    end else if (start_acc) begin
      perf_cycles_reg <= '0;
      perf_stall_reg  <= '0;
    end else begin
      if (busy_reg && perf_cycles_reg != '1) perf_cycles_reg <= perf_cycles_reg + 32'd1;
      if (stall_cond && perf_stall_reg != '1) perf_stall_reg <= perf_stall_reg + 32'd1;
    end
  end

  assign perf_cycles_o = perf_cycles_reg;
  assign perf_stall_o  = perf_stall_reg;
`endif

endmodule

// File: tb/tb_qracc_pass_sequencer.sv
// Bench for qracc_pass_sequencer: directed and random passes against an address/event list model.
module tb_qracc_pass_sequencer;

  logic        clk = 1'b0, nrst = 1'b0;
  logic        start_i = 1'b0, clear_i = 1'b0;
  logic [15:0] num_pixels_i = '0, num_loads_i = '0;
  logic [31:0] rd_base_i = '0, rd_stride_i = '0, wr_base_i = '0, wr_stride_i = '0;
  logic        buf_rd_en_o, fl_wr_en_o, mac_valid_o, wb_en_o, busy_o, done_o, err_o;
  logic [31:0] buf_rd_addr_o, fl_addr_o, wb_addr_o;
  logic        mac_ready_i = 1'b0, mac_done_i = 1'b0, wb_ready_i = 1'b0;
`ifdef QRACC_SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles_o, perf_stall_o;
`endif

  always #5 clk = ~clk;

  qracc_pass_sequencer dut (
    .clk(clk), .nrst(nrst), .start_i(start_i), .clear_i(clear_i),
    .num_pixels_i(num_pixels_i), .num_loads_i(num_loads_i),
    .rd_base_i(rd_base_i), .rd_stride_i(rd_stride_i),
    .wr_base_i(wr_base_i), .wr_stride_i(wr_stride_i),
    .buf_rd_en_o(buf_rd_en_o), .buf_rd_addr_o(buf_rd_addr_o),
    .fl_wr_en_o(fl_wr_en_o), .fl_addr_o(fl_addr_o),
    .mac_valid_o(mac_valid_o), .mac_ready_i(mac_ready_i), .mac_done_i(mac_done_i),
    .wb_en_o(wb_en_o), .wb_addr_o(wb_addr_o), .wb_ready_i(wb_ready_i),
    .busy_o(busy_o), .done_o(done_o),
`ifdef QRACC_SEQ_PERF_CNT_EN
    .perf_cycles_o(perf_cycles_o), .perf_stall_o(perf_stall_o),
`endif
    .err_o(err_o)
  );

  int n_checks = 0, n_errors = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observed event streams and responder state.
  logic [31:0] obs_rd[$];
  int          obs_fl[$];
  logic [31:0] obs_wb[$];
  int mac_acc, done_cnt, valid_cycles, wb_en_cycles, lag_bad, hold_bad;
  int mac_delay = -1, rdy_stall = 0, wb_stall = 0;
  int cfg_rdy_stall = -1, cfg_wb_stall = -1, cfg_done_delay = -1;
  logic prev_rd_en = 1'b0, prev_valid = 1'b0, prev_wb_en = 1'b0;
  logic [31:0] cur_wr_base = '0, cur_wr_stride = '0;

  task automatic reset_stats();
    obs_rd.delete(); obs_fl.delete(); obs_wb.delete();
    mac_acc = 0; done_cnt = 0; valid_cycles = 0; wb_en_cycles = 0; lag_bad = 0; hold_bad = 0;
  endtask

  // One clock: observe at the falling edge, then drive the seq_acc / writeback responders.
  task automatic cycle();
    logic [31:0] exp_wb;
    @(negedge clk);
    if (buf_rd_en_o) obs_rd.push_back(buf_rd_addr_o);
    if (fl_wr_en_o) obs_fl.push_back(int'(fl_addr_o));
    if (fl_wr_en_o !== prev_rd_en) lag_bad++;
    prev_rd_en = buf_rd_en_o;
    if (done_o) done_cnt++;
    mac_done_i = 1'b0;
    if (mac_delay == 0) begin mac_done_i = 1'b1; mac_delay = -1; end
    else if (mac_delay > 0) mac_delay--;
    if (mac_valid_o) begin
      valid_cycles++;
      if (!prev_valid) rdy_stall = (cfg_rdy_stall < 0) ? int'($urandom_range(0, 3)) : cfg_rdy_stall;
      mac_ready_i = (rdy_stall == 0);
      if (rdy_stall > 0) rdy_stall--;
      if (mac_ready_i) begin
        mac_acc++;
        mac_delay = (cfg_done_delay < 0) ? int'($urandom_range(0, 3)) : cfg_done_delay;
      end
    end else mac_ready_i = 1'($urandom_range(0, 1));
    prev_valid = mac_valid_o;
    if (wb_en_o) begin
      wb_en_cycles++;
      exp_wb = cur_wr_base + cur_wr_stride * 32'(obs_wb.size());
      if (wb_addr_o !== exp_wb) hold_bad++;
      if (!prev_wb_en) wb_stall = (cfg_wb_stall < 0) ? int'($urandom_range(0, 3)) : cfg_wb_stall;
      wb_ready_i = (wb_stall == 0);
      if (wb_stall > 0) wb_stall--;
      if (wb_ready_i) obs_wb.push_back(wb_addr_o);
    end else wb_ready_i = 1'($urandom_range(0, 1));
    prev_wb_en = wb_en_o;
  endtask

  task automatic start_pass(input int np, input int nl, input logic [31:0] rb, input logic [31:0] rs,
                            input logic [31:0] wb, input logic [31:0] ws);
    reset_stats();
    cur_wr_base = wb; cur_wr_stride = ws;
    num_pixels_i = 16'(np); num_loads_i = 16'(nl);
    rd_base_i = rb; rd_stride_i = rs; wr_base_i = wb; wr_stride_i = ws;
    start_i = 1'b1;
    cycle();
    start_i = 1'b0;
    // Scramble the config inputs so only the latched copy can produce the right pass.
    num_pixels_i = 16'($urandom); num_loads_i = 16'($urandom);
    rd_base_i = $urandom; rd_stride_i = $urandom; wr_base_i = $urandom; wr_stride_i = $urandom;
    check_val("busy_after_start", longint'(busy_o), 1);
  endtask

  task automatic run_pass(input int np, input int nl, input logic [31:0] rb, input logic [31:0] rs,
                          input logic [31:0] wb, input logic [31:0] ws, output int lat);
    int nle, total;
    logic [31:0] e;
    start_pass(np, nl, rb, rs, wb, ws);
    lat = 1;
    while (done_cnt == 0 && lat < 3000) begin cycle(); lat++; end
    check_val("done_seen", longint'(done_cnt), 1);
    check_val("busy_at_done", longint'(busy_o), 0);
    repeat (3) cycle();
    check_val("done_single_pulse", longint'(done_cnt), 1);
    nle = (nl == 0) ? 1 : nl;
    total = np * nle;
    check_val("rd_count", longint'(obs_rd.size()), longint'(total));
    for (int i = 0; i < obs_rd.size() && i < total; i++) begin
      e = rb + rs * 32'(i);
      check_val($sformatf("rd_addr[%0d]", i), longint'(obs_rd[i]), longint'(e));
    end
    check_val("fl_count", longint'(obs_fl.size()), longint'(total));
    for (int i = 0; i < obs_fl.size() && i < total; i++)
      check_val($sformatf("fl_slot[%0d]", i), longint'(obs_fl[i]), longint'(i % nle));
    check_val("wb_count", longint'(obs_wb.size()), longint'(np));
    for (int p = 0; p < obs_wb.size() && p < np; p++) begin
      e = wb + ws * 32'(p);
      check_val($sformatf("wb_addr[%0d]", p), longint'(obs_wb[p]), longint'(e));
    end
    check_val("mac_accepts", longint'(mac_acc), longint'(np));
    check_val("fl_lag", longint'(lag_bad), 0);
    check_val("wb_addr_hold", longint'(hold_bad), 0);
    check_val("err_clean", longint'(err_o), 0);
    $display("pass np=%0d nl=%0d rb=0x%0h rs=0x%0h wb=0x%0h ws=0x%0h cycles=%0d", np, nl, rb, rs, wb, ws, lat);
  endtask

  initial begin
    int lat, guard;
    // Reset state.
    #12;
    check_val("rst_busy", longint'(busy_o), 0);
    check_val("rst_done", longint'(done_o), 0);
    check_val("rst_err", longint'(err_o), 0);
    check_val("rst_enables", longint'({buf_rd_en_o, fl_wr_en_o, mac_valid_o, wb_en_o}), 0);
    check_val("rst_addrs", longint'(buf_rd_addr_o | wb_addr_o | fl_addr_o), 0);
    @(negedge clk);
    nrst = 1'b1;
    reset_stats();
    repeat (5) cycle();
    check_val("idle_no_reads", longint'(obs_rd.size() + valid_cycles + wb_en_cycles), 0);
    check_val("idle_busy", longint'(busy_o), 0);
    check_val("idle_no_done", longint'(done_cnt), 0);

    // Directed pass with MAC and writeback backpressure.
    cfg_rdy_stall = 4; cfg_wb_stall = 3;
    run_pass(2, 3, 32'h10, 32'h20, 32'h100, 32'h40, lat);
    check_val("mac_valid_cycles", longint'(valid_cycles), 10);
    check_val("wb_en_cycles", longint'(wb_en_cycles), 8);
    cfg_rdy_stall = -1; cfg_wb_stall = -1;

    // Empty pass: done pulse two cycles after start, no datapath activity.
    run_pass(0, 3, 32'h10, 32'h20, 32'h100, 32'h40, lat);
    check_val("zero_pix_latency", longint'(lat), 2);
    check_val("zero_pix_activity", longint'(valid_cycles + wb_en_cycles), 0);

    // Start together with clear is dropped.
    reset_stats();
    num_pixels_i = 16'd2; num_loads_i = 16'd2;
    start_i = 1'b1; clear_i = 1'b1;
    cycle();
    start_i = 1'b0; clear_i = 1'b0;
    check_val("start_clear_busy", longint'(busy_o), 0);
    repeat (4) cycle();
    check_val("start_clear_no_activity", longint'(obs_rd.size() + done_cnt), 0);
    $display("start+clear dropped: busy=%0b reads=%0d", busy_o, obs_rd.size());

    // Clear while waiting on the MAC result.
    cfg_done_delay = 50;
    start_pass(3, 2, 32'h0, 32'h4, 32'h200, 32'h8);
    guard = 0;
    while (mac_acc == 0 && guard < 200) begin cycle(); guard++; end
    check_val("clear_reached_mac", longint'(mac_acc), 1);
    cycle(); cycle();
    check_val("clear_in_wait_busy", longint'(busy_o & ~mac_valid_o & ~wb_en_o), 1);
    clear_i = 1'b1;
    cycle();
    clear_i = 1'b0; mac_delay = -1; cfg_done_delay = -1;
    check_val("clear_busy", longint'(busy_o), 0);
    check_val("clear_enables", longint'({buf_rd_en_o, mac_valid_o, wb_en_o}), 0);
    repeat (5) cycle();
    check_val("clear_no_done", longint'(done_cnt), 0);
    check_val("clear_no_err", longint'(err_o), 0);
    $display("clear in WAIT: busy=%0b done_pulses=%0d", busy_o, done_cnt);

    // Spurious MAC result while idle sets a sticky error until clear.
    mac_delay = 0;
    cycle();
    cycle();
    check_val("spurious_err_set", longint'(err_o), 1);
    repeat (3) cycle();
    check_val("spurious_err_sticky", longint'(err_o), 1);
    clear_i = 1'b1;
    cycle();
    clear_i = 1'b0;
    check_val("spurious_err_cleared", longint'(err_o), 0);
    $display("spurious mac_done: err cleared=%0b", ~err_o);

    // Asynchronous reset mid-pass.
    start_pass(4, 3, 32'h1000, 32'h10, 32'h2000, 32'h10);
    repeat (7) cycle();
    #2 nrst = 1'b0;
    #1;
    check_val("async_rst_enables", longint'({buf_rd_en_o, fl_wr_en_o, mac_valid_o, wb_en_o}), 0);
    check_val("async_rst_flags", longint'({busy_o, done_o, err_o}), 0);
    check_val("async_rst_addrs", longint'(buf_rd_addr_o | wb_addr_o | fl_addr_o), 0);
    mac_delay = -1; mac_done_i = 1'b0;
    prev_rd_en = 1'b0; prev_valid = 1'b0; prev_wb_en = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    $display("async reset mid-pass: outputs returned to reset values");

    // Random passes, including num_loads=0 and wrapping addresses.
    for (int t = 0; t < 8; t++)
      run_pass(int'($urandom_range(1, 4)), int'($urandom_range(0, 5)),
               $urandom, $urandom, $urandom, $urandom, lat);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
